rvfi_mem_responder: RTL and testbench
=====================================

Name: rvfi_mem_responder

Overview:
Parametrised memory-side responder for the picorv32-style native memory bus (valid/ready, one transaction outstanding), used by formal wrappers and simulation benches. It replaces free-running random `mem_ready`/`mem_rdata` plus an ad-hoc fairness restrict.
- Bounded-latency responder FSM: random or fixed latency, with a guaranteed wait bound.
- Optional byte-strobed backing store, so reads return previously written data.
- Sticky protocol checker on the request signals.
Random choices enter as ports; the wrapper binds them to `rvformal_rand_reg`.

Parameters:
- ADDR_WIDTH, 32, width of `mem_addr`.
- DATA_WIDTH, 32, bus data width; must be a multiple of 8.
- DEPTH_LOG2, 8, backing store holds 2**DEPTH_LOG2 words.
- MODE, 1: 0 = stateless (`rdata` always from `rand_rdata`); 1 = store-backed.
- MAX_WAIT, 3, fairness bound: maximum WAIT cycles before `mem_ready` is forced (random-latency mode).
- FIXED_LATENCY, 0: 0 = random latency; L>0 = deterministic response, `rand_ready` ignored.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  request valid from core.
- mem_instr  in  1  instruction-fetch flag.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wstrb  in  DATA_WIDTH/8  byte write strobes; all-zero = read.
- mem_ready  out  1  registered, one-cycle response strobe.
- mem_rdata  out  DATA_WIDTH  registered read data, valid while `mem_ready`.
- rand_ready  in  1  free-choice ready (random mode).
- rand_rdata  in  DATA_WIDTH  free-choice data (MODE 0, and all writes).
- halt  in  1  core trapped/halted; disables forced ready.
- busy  out  1  state != IDLE.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset (async, `resetn`=0):
  - state=IDLE, `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, `wait_cnt`=0, capture registers 0.
  - Backing store is NOT reset; its contents are undefined after power-up.
  - Reset during WAIT/RESP drops `mem_ready` immediately and preserves the store.
- States IDLE, WAIT, RESP:
  - IDLE: `mem_ready`=0. If `mem_valid`, capture addr/wdata/wstrb/instr, `wait_cnt`<=0, go to WAIT.
  - WAIT: evaluate `fire` each cycle. On `fire`: `mem_ready`<=1, `mem_rdata`<=response, perform store write, go to RESP. Otherwise `wait_cnt`<=`wait_cnt`+1, saturating at max(MAX_WAIT, FIXED_LATENCY).
  - RESP: `mem_ready` is high this cycle; next state IDLE with `mem_ready`<=0. A `mem_valid` that is still high the cycle after RESP is a new request.
- fire:
  - FIXED_LATENCY=L>0: `fire` = (`wait_cnt`==L-1); `halt` is ignored.
  - FIXED_LATENCY=0: `fire` = `rand_ready` || (`wait_cnt`==MAX_WAIT && !`halt`).
- Latency, with valid first seen in cycle t:
  - `mem_ready` is high no earlier than cycle t+2.
  - Fixed mode: `mem_ready` high at exactly t+1+L.
  - Random mode with `halt`=0: `mem_ready` high at latest t+2+MAX_WAIT.
  - Random mode with `halt`=1: unbounded.
- Response data:
  - Read in MODE 1: `mem_rdata` = store[idx].
  - Read in MODE 0, or any write: `mem_rdata` = `rand_rdata`.
- Store indexing:
  - idx = `mem_addr`[clog2(DATA_WIDTH/8) +: DEPTH_LOG2].
  - Upper address bits are ignored, so addresses alias modulo the store size.
  - Sub-word low address bits are ignored.
- Store write: only on `fire`, only if MODE=1. Byte k is written iff `wstrb`[k].
- Protocol check, WAIT state only:
  - Violation = `mem_valid`==0, or addr/wdata/wstrb/instr differ from the captured values.
  - Violation sets `proto_err`<=1, which stays set until reset.
  - FSM continues using the captured values.
- Elaboration asserts:
  - DATA_WIDTH%8==0.
  - DEPTH_LOG2 <= ADDR_WIDTH-clog2(DATA_WIDTH/8).
- Counter width: clog2(max(MAX_WAIT, FIXED_LATENCY)+1), minimum 1.

Decomposition:
- Package `rvfi_mem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - MODE_STATELESS/MODE_STORE constants;
  - clog2-based width helper functions.
- Sub-module `rvfi_mem_store`:
  - DATA_WIDTH x 2**DEPTH_LOG2 byte-strobed RAM;
  - synchronous write port;
  - combinational read port;
  - no reset.

Test Plan:
1. MODE=1, FIXED_LATENCY=3: write 0xDEADBEEF, wstrb 4'b1111, addr 0x10, valid at t -> `mem_ready` high only at t+4. Then read addr 0x10 -> `mem_rdata`=0xDEADBEEF with `mem_ready`.
2. Partial strobe: write 0x000000AA, wstrb 4'b0001 to 0x10, then read 0x10 -> 0xDEADBEAA. With DEPTH_LOG2=4, read 0x50 (aliases 0x10) -> 0xDEADBEAA.
3. Random mode, MAX_WAIT=3, `rand_ready`=0 constantly, `halt`=0: read at t -> `mem_ready` at exactly t+5, high for one cycle, `busy` low at t+6.
4. Random mode, `halt`=1, `rand_ready`=0 for 20 cycles -> no `mem_ready`, `wait_cnt` saturates at 3. Deassert `halt` at cycle h -> `mem_ready` at h+1. Alternatively, `rand_ready`=1 in the first WAIT cycle -> `mem_ready` at t+2.
5. Protocol: change `mem_addr` 0x10->0x14 while in WAIT -> `proto_err`=1 next cycle. Response still uses 0x10. `proto_err` stays 1 until `resetn` pulses low.
6. Reset mid-WAIT after a completed write of 0x12345678 to 0x20: assert `resetn`=0 -> `mem_ready`=0 and `busy`=0 immediately. After release, read 0x20 -> 0x12345678.

Source files
------------

// File: rtl/rvfi_mem_pkg.sv
// -----------------------------------------------------------------------------
// rvfi_mem_pkg
// Shared types and elaboration helpers for the picorv32-style memory responder:
//   - state_t         : responder FSM states (IDLE / WAIT / RESP)
//   - MODE_*          : stateless vs. store-backed response data
//   - max2/cnt_width  : wait-counter sizing
//   - byte_off        : number of sub-word byte address bits
// -----------------------------------------------------------------------------
package rvfi_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MODE_STATELESS = 0;
    localparam int MODE_STORE     = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width needed to count 0..max(max_wait, fixed_latency); never below 1 bit.
    function automatic int cnt_width(input int max_wait, input int fixed_latency);
        int w;
        w = $clog2(max2(max_wait, fixed_latency) + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int byte_off(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rvfi_mem_store.sv
// -----------------------------------------------------------------------------
// rvfi_mem_store
// DATA_WIDTH x 2**DEPTH_LOG2 byte-strobed backing RAM.
// Ports:
//   clock  - write clock
//   we     - write enable (bytes selected by wstrb)
//   addr   - word index shared by the write and read ports
//   wdata  - write data
//   wstrb  - per-byte write enables
//   rdata  - combinational read data at addr
// -----------------------------------------------------------------------------
module rvfi_mem_store
    import rvfi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset branch on purpose; contents survive resetn and
    // are undefined at power-up, which keeps this a plain RAM for synthesis.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wstrb[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/rvfi_mem_responder.sv
// -----------------------------------------------------------------------------
// rvfi_mem_responder
// Memory-side responder for the picorv32 native bus (one outstanding request).
// Bounded-latency response FSM, optional byte-strobed backing store and a
// sticky protocol checker on the request signals.
// Ports:
//   clock, resetn        - clock, asynchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb - request from the core (wstrb==0: read)
//   mem_ready, mem_rdata - registered one-cycle response strobe and data
//   rand_ready           - free-choice ready (random-latency mode)
//   rand_rdata           - free-choice data (stateless reads and all writes)
//   halt                 - core halted; suppresses the forced ready
//   busy                 - a request is being served (state != IDLE)
//   proto_err            - sticky request-protocol violation flag
// -----------------------------------------------------------------------------
module rvfi_mem_responder
    import rvfi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_LOG2    = 8,
    parameter int MODE          = 1,
    parameter int MAX_WAIT      = 3,
    parameter int FIXED_LATENCY = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    rand_ready,
    input  logic [DATA_WIDTH-1:0]   rand_rdata,
    input  logic                    halt,
    output logic                    busy,
    output logic                    proto_err
);

    localparam int BYTE_OFF = byte_off(DATA_WIDTH);
    localparam int CNT_MAX  = max2(MAX_WAIT, FIXED_LATENCY);
    localparam int CNT_W    = cnt_width(MAX_WAIT, FIXED_LATENCY);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    // Counter value on which the response fires: L-1 in fixed mode (ready then
    // lands at t+1+L), MAX_WAIT in random mode (forced-ready fairness bound).
    localparam logic [CNT_W-1:0] FIRE_AT = (FIXED_LATENCY > 0) ? CNT_W'(FIXED_LATENCY - 1)
                                                               : CNT_W'(MAX_WAIT);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("rvfi_mem_responder: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH_LOG2 > ADDR_WIDTH - BYTE_OFF) begin : g_bad_depth
        $error("rvfi_mem_responder: DEPTH_LOG2 exceeds the word address width");
    end

    state_t                  state;
    logic [CNT_W-1:0]        wait_cnt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH/8-1:0] cap_wstrb;
    logic                    cap_instr;

    logic                    fire;
    logic                    mismatch;
    logic                    store_we;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   store_rdata;
    logic [DATA_WIDTH-1:0]   resp_data;

    // Upper address bits and sub-word bits are dropped, so addresses alias
    // modulo the store size.
    assign idx = cap_addr[BYTE_OFF +: DEPTH_LOG2];

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fire = 1'b0;
        if (FIXED_LATENCY > 0) begin
            fire = (wait_cnt == FIRE_AT);
        end else begin
            fire = rand_ready || ((wait_cnt == FIRE_AT) && !halt);
        end
    end

    assign mismatch = !mem_valid
                   || (mem_addr  != cap_addr)
                   || (mem_wdata != cap_wdata)
                   || (mem_wstrb != cap_wstrb)
                   || (mem_instr != cap_instr);

    assign store_we = (state == ST_WAIT) && fire;

    if (MODE == MODE_STORE) begin : g_store
        rvfi_mem_store #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_store (
            .clock (clock),
            .we    (store_we),
            .addr  (idx),
            .wdata (cap_wdata),
            .wstrb (cap_wstrb),
            .rdata (store_rdata)
        );
    end else begin : g_no_store
        assign store_rdata = '0;
    end

    // Only store-backed reads return memory contents; writes echo rand_rdata.
    assign resp_data = ((MODE == MODE_STORE) && (cap_wstrb == '0)) ? store_rdata : rand_rdata;

    // NOTE: registered state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cap_instr <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_valid) begin
                        cap_addr  <= mem_addr;
                        cap_wdata <= mem_wdata;
                        cap_wstrb <= mem_wstrb;
                        cap_instr <= mem_instr;
                        wait_cnt  <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The request must be held stable; on violation keep
                    // serving the captured request and flag it.
                    if (mismatch) begin
                        proto_err <= 1'b1;
                    end
                    if (fire) begin
                        mem_ready <= 1'b1;
                        mem_rdata <= resp_data;
                        state     <= ST_RESP;
                    end else if (wait_cnt != CNT_SAT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    mem_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_rvfi_mem_responder
// Two responders share one request bus: dut_a uses random latency
// (MAX_WAIT=3), dut_b a fixed latency of 3. Both are store-backed with a
// 16-word store. Every request pushes the expected data and response cycle
// for each DUT into a queue; a monitor pops and compares on mem_ready.
// -----------------------------------------------------------------------------
module tb_rvfi_mem_responder;

    localparam int MAX_WAIT = 3;
    localparam int FIXED    = 3;
    localparam int SEQ_LEN  = 24;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic        a_valid, b_valid;
    logic        m_instr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        rand_ready;
    logic [31:0] rand_rdata;
    logic        halt;

    logic        a_ready, b_ready;
    logic [31:0] a_rdata, b_rdata;
    logic        a_busy, b_busy;
    logic        a_perr, b_perr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [31:0] mem_model [16];
    bit          rr_seq [SEQ_LEN];
    bit          h_seq  [SEQ_LEN];

    rvfi_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(4),
        .MODE(1), .MAX_WAIT(MAX_WAIT), .FIXED_LATENCY(0)
    ) dut_a (
        .clock(clock), .resetn(resetn),
        .mem_valid(a_valid), .mem_instr(m_instr), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(a_ready), .mem_rdata(a_rdata),
        .rand_ready(rand_ready), .rand_rdata(rand_rdata), .halt(halt),
        .busy(a_busy), .proto_err(a_perr)
    );

    rvfi_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(4),
        .MODE(1), .MAX_WAIT(MAX_WAIT), .FIXED_LATENCY(FIXED)
    ) dut_b (
        .clock(clock), .resetn(resetn),
        .mem_valid(b_valid), .mem_instr(m_instr), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(b_ready), .mem_rdata(b_rdata),
        .rand_ready(rand_ready), .rand_rdata(rand_rdata), .halt(halt),
        .busy(b_busy), .proto_err(b_perr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: each response must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (resetn && a_ready) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_spurious_ready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_a.pop_front();
                check("a_rdata", a_rdata, e.data);
                check("a_latency", cyc, e.cyc);
            end
        end
        if (resetn && b_ready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_spurious_ready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_b.pop_front();
                check("b_rdata", b_rdata, e.data);
                check("b_latency", cyc, e.cyc);
            end
        end
    end

    task automatic zero_seq();
        for (int j = 0; j < SEQ_LEN; j++) begin
            rr_seq[j] = 1'b0;
            h_seq[j]  = 1'b0;
        end
    endtask

    task automatic random_seq();
        for (int j = 0; j < SEQ_LEN; j++) begin
            rr_seq[j] = ($urandom_range(0, 3) == 0);
            h_seq[j]  = (j < 12) && ($urandom_range(0, 3) == 0);
        end
    endtask

    // One request to both DUTs. rr_seq/h_seq give rand_ready/halt for each WAIT
    // cycle j. Random-mode reference: the response fires in the first WAIT
    // cycle j where rand_ready is set, or where j >= MAX_WAIT and halt is clear;
    // mem_ready follows in the next cycle. Fixed mode answers at t+1+L.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit glitch,
                         input bit chk_sat, output int t);
        logic [31:0] rdat;
        int          idx;
        int          jf;
        int          k;
        bit          a_done, b_done;
        exp_t        e;

        @(negedge clock);
        rdat = $urandom;
        idx  = int'((addr >> 2) & 32'hF);
        jf   = SEQ_LEN;
        for (int j = SEQ_LEN - 1; j >= 0; j--) begin
            if (rr_seq[j] || (j >= MAX_WAIT && !h_seq[j])) jf = j;
        end
        e.data = (wstrb == 4'h0) ? mem_model[idx] : rdat;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_model[idx][8*b +: 8] = wdata[8*b +: 8];
        end

        m_addr     = addr;
        m_wdata    = wdata;
        m_wstrb    = wstrb;
        m_instr    = 1'($urandom);
        rand_rdata = rdat;
        rand_ready = 1'b0;
        halt       = 1'b0;
        a_valid    = 1'b1;
        b_valid    = 1'b1;
        t          = cyc;
        e.cyc = t + 2 + jf;
        exp_a.push_back(e);
        e.cyc = t + 1 + FIXED;
        exp_b.push_back(e);

        a_done = 1'b0;
        b_done = 1'b0;
        k      = 0;
        while (!(a_done && b_done) && k < 40) begin
            k++;
            @(negedge clock);
            if (a_valid && a_ready) begin a_valid = 1'b0; a_done = 1'b1; end
            if (b_valid && b_ready) begin b_valid = 1'b0; b_done = 1'b1; end
            rand_ready = (k - 1 < SEQ_LEN) ? rr_seq[k-1] : 1'b0;
            halt       = (k - 1 < SEQ_LEN) ? h_seq[k-1]  : 1'b0;
            if (glitch && k == 1) m_addr = addr ^ 32'h4;
            if (glitch && k == 2) begin
                check("a_proto_err_set", a_perr, 1);
                check("b_proto_err_set", b_perr, 1);
            end
            if (chk_sat && k == 15) check("a_wait_cnt_sat", 64'(dut_a.wait_cnt), MAX_WAIT);
        end
        if (!(a_done && b_done)) begin
            checks++; errors++;
            $display("FAIL response_timeout: got a_done=%0d b_done=%0d expected 1 1", a_done, b_done);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        rand_ready = 1'b0;
        halt       = 1'b0;
    endtask

    initial begin
        int t;
        clock = 1'b0; resetn = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; m_instr = 1'b0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0;
        rand_ready = 1'b0; rand_rdata = '0; halt = 1'b0;
        for (int i = 0; i < 16; i++) mem_model[i] = '0;

        repeat (3) @(negedge clock);
        check("a_reset_ready", a_ready, 0);
        check("a_reset_rdata", a_rdata, 0);
        check("a_reset_busy",  a_busy,  0);
        check("a_reset_perr",  a_perr,  0);
        check("b_reset_ready", b_ready, 0);
        check("b_reset_rdata", b_rdata, 0);
        check("b_reset_busy",  b_busy,  0);
        check("b_reset_perr",  b_perr,  0);
        resetn = 1'b1;

        // Full write, read back, partial write, aliased read.
        zero_seq();
        issue(32'h10, 32'hDEADBEEF, 4'b1111, 0, 0, t);
        issue(32'h10, 32'h0,        4'b0000, 0, 0, t);
        issue(32'h10, 32'h000000AA, 4'b0001, 0, 0, t);
        issue(32'h10, 32'h0,        4'b0000, 0, 0, t);
        issue(32'h50, 32'h0,        4'b0000, 0, 0, t);

        // Forced ready after MAX_WAIT; busy drops the cycle after the response.
        issue(32'h10, 32'h0, 4'b0000, 0, 0, t);
        @(negedge clock);
        check("a_busy_after_resp", a_busy, 0);

        // Halt holds the request; release lets it fire on the next edge.
        zero_seq();
        for (int j = 0; j < 20; j++) h_seq[j] = 1'b1;
        issue(32'h10, 32'h0, 4'b0000, 0, 1, t);

        // rand_ready in the first WAIT cycle answers at t+2.
        zero_seq();
        rr_seq[0] = 1'b1;
        issue(32'h10, 32'h0, 4'b0000, 0, 0, t);

        // Randomised traffic: fill every word, then mixed reads and writes.
        for (int i = 0; i < 16; i++) begin
            random_seq();
            issue(($urandom & 32'hFFFF_FFC3) | (32'(i) << 2), $urandom, 4'b1111, 0, 0, t);
        end
        for (int i = 0; i < 60; i++) begin
            random_seq();
            issue($urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), 0, 0, t);
        end
        check("a_perr_clean", a_perr, 0);
        check("b_perr_clean", b_perr, 0);

        zero_seq();
        issue(32'h20, 32'h12345678, 4'b1111, 0, 0, t);

        // Address changes mid-WAIT: flag set, captured address still served.
        issue(32'h10, 32'h0, 4'b0000, 1, 0, t);
        issue(32'h20, 32'h0, 4'b0000, 0, 0, t);
        check("a_perr_sticky", a_perr, 1);
        check("b_perr_sticky", b_perr, 1);

        // Reset in the middle of WAIT: outputs drop at once, store survives.
        @(negedge clock);
        m_addr = 32'h20; m_wstrb = 4'h0; m_wdata = '0;
        halt = 1'b1; rand_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("a_busy_mid_wait", a_busy, 1);
        check("b_busy_mid_wait", b_busy, 1);
        resetn = 1'b0;
        #1;
        check("a_ready_in_reset", a_ready, 0);
        check("a_busy_in_reset",  a_busy,  0);
        check("b_ready_in_reset", b_ready, 0);
        check("b_busy_in_reset",  b_busy,  0);
        check("a_perr_in_reset",  a_perr,  0);
        a_valid = 1'b0; b_valid = 1'b0; halt = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        issue(32'h20, 32'h0, 4'b0000, 0, 0, t);
        check("a_perr_after_reset", a_perr, 0);
        check("b_perr_after_reset", b_perr, 0);

        repeat (3) @(negedge clock);
        check("a_pending", exp_a.size(), 0);
        check("b_pending", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
